door_lock_ctrl_param: RTL

Parametrised door-lock controller. It takes a key-strobe interface, stores a digit password of configurable length internally, and compares entered codes against it. It supports password change, failed-attempt counting with timed lockout, and inactivity timeouts. It sits between the keypad/switch decoder and the LED and seven-segment display drivers.

---
 rtl/door_lock_ctrl_param.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/door_lock_ctrl_param.sv
// rtl/door_lock_ctrl_param.sv - parametrised keypad door-lock controller
//
// Stores an N_DIGITS BCD password and checks entered codes against it.
// Supports password change, consecutive-failure lockout and idle timeouts.
//
// Ports:
//   clk            system clock, all state on rising edge
//   reset_n        asynchronous active-low reset
//   key_valid      one-cycle key strobe
//   key_code       0-9 digit, 10 clear, 11 enter/lock, 12 change, 13-15 reserved
//   current_state  0 LOCK, 1 ENTRY, 2 OPEN, 3 CHANGE, 4 LOCKOUT
//   led_out        active-low unlocked indicator (0 in OPEN/CHANGE)
//   disp_mode      10 ENTRY, 01 CHANGE, 11 LOCKOUT, 00 otherwise
//   entry_digits   entry buffer, first digit in the top nibble
//   cursor         number of digits entered
//   fail_cnt       consecutive failed entries
//   pw_ok, pw_bad  one-cycle result pulses
module door_lock_ctrl_param #(
    parameter int N_DIGITS       = 4,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int IDLE_TIMEOUT   = 5000,
    parameter logic [4*N_DIGITS-1:0] DEFAULT_PW = {N_DIGITS{4'h0}}
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    output logic [2:0]                    current_state,
    output logic                          led_out,
    output logic [1:0]                    disp_mode,
    output logic [4*N_DIGITS-1:0]         entry_digits,
    output logic [$clog2(N_DIGITS+1)-1:0] cursor,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output logic                          pw_ok,
    output logic                          pw_bad
);

    localparam int CW = $clog2(N_DIGITS+1);
    localparam int FW = $clog2(MAX_FAIL+1);
    localparam int IW = $clog2(IDLE_TIMEOUT+1);
    localparam int LW = $clog2(LOCKOUT_CYCLES+1);

    localparam logic [3:0] KEY_CLEAR  = 4'd10;
    localparam logic [3:0] KEY_ENTER  = 4'd11;
    localparam logic [3:0] KEY_CHANGE = 4'd12;

    typedef enum logic [2:0] {
        S_LOCK    = 3'd0,
        S_ENTRY   = 3'd1,
        S_OPEN    = 3'd2,
        S_CHANGE  = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [4*N_DIGITS-1:0] stored_pw, pw_nxt;
    logic [4*N_DIGITS-1:0] entry_nxt, entry_ins;
    logic [CW-1:0]         cursor_nxt;
    logic [FW-1:0]         fail_nxt, fail_inc;
    logic                  ok_nxt, bad_nxt;
    logic                  led_nxt;
    logic [1:0]            disp_nxt;
    logic [IW-1:0]         idle_cnt;
    logic [LW-1:0]         lock_cnt;

    logic key_acc, is_digit, full, idle_exp, match;

    // Reserved codes are invisible: they neither act nor reload the idle timer.
    assign key_acc  = key_valid && (key_code <= KEY_CHANGE);
    assign is_digit = key_code <= 4'd9;
    assign full     = (cursor == CW'(N_DIGITS));
    assign match    = full && (entry_digits == stored_pw);
    assign fail_inc = fail_cnt + FW'(1);
    // idle_cnt holds the number of quiet cycles already completed, so the
    // current cycle is the last allowed one when it reads IDLE_TIMEOUT-1.
    assign idle_exp = (idle_cnt == IW'(IDLE_TIMEOUT-1));

    assign current_state = state;

    // Buffer with the pressed digit written at the cursor position.
    always_comb begin
        entry_ins = entry_digits;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (int'(cursor) == N_DIGITS-1-i) begin
                entry_ins[4*i +: 4] = key_code;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_LOCK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decisions
    always_comb begin
        state_nxt  = state;
        entry_nxt  = entry_digits;
        cursor_nxt = cursor;
        fail_nxt   = fail_cnt;
        pw_nxt     = stored_pw;
        ok_nxt     = 1'b0;
        bad_nxt    = 1'b0;
        case (state)
            S_LOCK: begin
                if (key_acc && key_code == KEY_ENTER) begin
                    state_nxt  = S_ENTRY;
                    entry_nxt  = '0;
                    cursor_nxt = '0;
                end
            end
            S_ENTRY: begin
                if (key_acc) begin
                    if (is_digit) begin
                        if (!full) begin
                            entry_nxt  = entry_ins;
                            cursor_nxt = cursor + CW'(1);
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        entry_nxt  = '0;
                        cursor_nxt = '0;
                    end else if (key_code == KEY_ENTER) begin
                        entry_nxt  = '0;
                        cursor_nxt = '0;
                        if (match) begin
                            state_nxt = S_OPEN;
                            fail_nxt  = '0;
                            ok_nxt    = 1'b1;
                        end else begin
                            bad_nxt   = 1'b1;
                            fail_nxt  = fail_inc;
                            state_nxt = (fail_inc == FW'(MAX_FAIL)) ? S_LOCKOUT : S_LOCK;
                        end
                    end
                end else if (idle_exp) begin
                    state_nxt  = S_LOCK;
                    entry_nxt  = '0;
                    cursor_nxt = '0;
                end
            end
            S_OPEN: begin
                if (key_acc) begin
                    if (key_code == KEY_ENTER) begin
                        state_nxt = S_LOCK;
                    end else if (key_code == KEY_CHANGE) begin
                        state_nxt  = S_CHANGE;
                        entry_nxt  = '0;
                        cursor_nxt = '0;
                    end
                end else if (idle_exp) begin
                    state_nxt = S_LOCK;
                end
            end
            S_CHANGE: begin
                if (key_acc) begin
                    if (is_digit) begin
                        if (!full) begin
                            entry_nxt  = entry_ins;
                            cursor_nxt = cursor + CW'(1);
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        entry_nxt  = '0;
                        cursor_nxt = '0;
                    end else begin
                        // Enter or change: back to OPEN; only a full change commits.
                        if (key_code == KEY_CHANGE && full) begin
                            pw_nxt = entry_digits;
                        end
                        state_nxt  = S_OPEN;
                        entry_nxt  = '0;
                        cursor_nxt = '0;
                    end
                end else if (idle_exp) begin
                    state_nxt  = S_OPEN;
                    entry_nxt  = '0;
                    cursor_nxt = '0;
                end
            end
            S_LOCKOUT: begin
                if (lock_cnt == LW'(LOCKOUT_CYCLES-1)) begin
                    state_nxt = S_LOCK;
                    fail_nxt  = '0;
                end
            end
            default: begin
                state_nxt  = S_LOCK;
                entry_nxt  = '0;
                cursor_nxt = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered indicators
    // change together with current_state.
    always_comb begin
        led_nxt  = !(state_nxt == S_OPEN || state_nxt == S_CHANGE);
        disp_nxt = 2'b00;
        case (state_nxt)
            S_ENTRY:   disp_nxt = 2'b10;
            S_CHANGE:  disp_nxt = 2'b01;
            S_LOCKOUT: disp_nxt = 2'b11;
            default:   disp_nxt = 2'b00;
        endcase
    end

    // Datapath, timer and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_digits <= '0;
            cursor       <= '0;
            fail_cnt     <= '0;
            stored_pw    <= DEFAULT_PW;
            pw_ok        <= 1'b0;
            pw_bad       <= 1'b0;
            led_out      <= 1'b1;
            disp_mode    <= 2'b00;
            idle_cnt     <= '0;
            lock_cnt     <= '0;
        end else begin
            entry_digits <= entry_nxt;
            cursor       <= cursor_nxt;
            fail_cnt     <= fail_nxt;
            stored_pw    <= pw_nxt;
            pw_ok        <= ok_nxt;
            pw_bad       <= bad_nxt;
            led_out      <= led_nxt;
            disp_mode    <= disp_nxt;

            if (state_nxt != state || key_acc) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IW'(IDLE_TIMEOUT)) begin
                idle_cnt <= idle_cnt + IW'(1);
            end

            if (state_nxt != state) begin
                lock_cnt <= '0;
            end else if (state == S_LOCKOUT && lock_cnt != LW'(LOCKOUT_CYCLES)) begin
                lock_cnt <= lock_cnt + LW'(1);
            end
        end
    end

endmodule
